// File: rtl/rv_operand_stage_if.sv
// ---------------------------------------------------------------------------
// rv_operand_stage_if
//
// Groups the ID-side inputs, the bypass sources and the registered ID/EX
// outputs of the rv32i operand stage into one bundle.
//
//   master : the surrounding pipeline. It drives the decoded instruction,
//            the register-file read data, the EX/MEM/WB bypass sources and
//            the flush. It receives the read addresses, the stall and the
//            ID/EX register contents.
//   slave  : rv_operand_stage itself.
//
// Signal groups:
//   ID instruction : i_os_valid, i_os_rs1/rs2(+_used), i_os_rd, i_os_wen,
//                    i_os_is_load, i_os_pc, i_os_imm
//   register file  : o_os_raddr[1:2] (out), i_os_rf_rdata[1:2] (in)
//   bypass sources : i_os_ex_result, i_os_mem_*, i_os_wb_*
//   control        : i_os_flush (in), o_os_stall (out)
//   ID/EX register : o_os_ex_* and o_os_stall_cnt (out)
// ---------------------------------------------------------------------------
interface rv_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  // decoded ID instruction
  logic             i_os_valid;
  logic [4:0]       i_os_rs1;
  logic [4:0]       i_os_rs2;
  logic             i_os_rs1_used;
  logic             i_os_rs2_used;
  logic [4:0]       i_os_rd;
  logic             i_os_wen;
  logic             i_os_is_load;
  logic [XLEN-1:0]  i_os_pc;
  logic [XLEN-1:0]  i_os_imm;

  // register-file read port
  logic [4:0]       o_os_raddr    [1:2];
  logic [XLEN-1:0]  i_os_rf_rdata [1:2];

  // bypass sources
  logic [XLEN-1:0]  i_os_ex_result;
  logic [4:0]       i_os_mem_rd;
  logic             i_os_mem_wen;
  logic [XLEN-1:0]  i_os_mem_data;
  logic [4:0]       i_os_wb_rd;
  logic             i_os_wb_wen;
  logic [XLEN-1:0]  i_os_wb_data;

  // pipeline control
  logic             i_os_flush;
  logic             o_os_stall;

  // ID/EX pipeline register
  logic             o_os_ex_valid;
  logic             o_os_ex_wen;
  logic             o_os_ex_is_load;
  logic [4:0]       o_os_ex_rd;
  logic [XLEN-1:0]  o_os_ex_rs1_data;
  logic [XLEN-1:0]  o_os_ex_rs2_data;
  logic [XLEN-1:0]  o_os_ex_pc;
  logic [XLEN-1:0]  o_os_ex_imm;
  logic [CNT_W-1:0] o_os_stall_cnt;

  modport master (
    output i_os_valid, i_os_rs1, i_os_rs2, i_os_rs1_used, i_os_rs2_used,
           i_os_rd, i_os_wen, i_os_is_load, i_os_pc, i_os_imm,
           i_os_rf_rdata, i_os_ex_result,
           i_os_mem_rd, i_os_mem_wen, i_os_mem_data,
           i_os_wb_rd, i_os_wb_wen, i_os_wb_data, i_os_flush,
    input  o_os_raddr, o_os_stall,
           o_os_ex_valid, o_os_ex_wen, o_os_ex_is_load, o_os_ex_rd,
           o_os_ex_rs1_data, o_os_ex_rs2_data, o_os_ex_pc, o_os_ex_imm,
           o_os_stall_cnt
  );

  modport slave (
    input  i_os_valid, i_os_rs1, i_os_rs2, i_os_rs1_used, i_os_rs2_used,
           i_os_rd, i_os_wen, i_os_is_load, i_os_pc, i_os_imm,
           i_os_rf_rdata, i_os_ex_result,
           i_os_mem_rd, i_os_mem_wen, i_os_mem_data,
           i_os_wb_rd, i_os_wb_wen, i_os_wb_data, i_os_flush,
    output o_os_raddr, o_os_stall,
           o_os_ex_valid, o_os_ex_wen, o_os_ex_is_load, o_os_ex_rd,
           o_os_ex_rs1_data, o_os_ex_rs2_data, o_os_ex_pc, o_os_ex_imm,
           o_os_stall_cnt
  );

endinterface

// File: rtl/rv_operand_stage.sv
// ---------------------------------------------------------------------------
// rv_operand_stage
//
// ID-to-EX operand stage of the rv32i pipeline.
//   - Drives the register-file read addresses straight from rs1/rs2.
//   - Resolves each source operand by bypassing from EX, MEM and WB, in
//     that priority, with x0 always reading as zero.
//   - Detects a load in EX feeding the ID instruction (load-use). It stalls
//     upstream and inserts one bubble into ID/EX.
//   - Registers operands plus control into the ID/EX register (1 cycle).
//   - Keeps a saturating count of stall cycles.
//
// Ports:
//   i_os_clk : clock
//   i_os_rst : asynchronous, active-high reset; clears every register
//   os       : rv_operand_stage_if.slave bundle (see the interface file)
// ---------------------------------------------------------------------------
module rv_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic               i_os_clk,
  input logic               i_os_rst,
  rv_operand_stage_if.slave os
);

  logic [4:0]      rs       [1:2];
  logic            rs_used  [1:2];
  logic [XLEN-1:0] operand  [1:2];
  logic            ex_fwd_ok;
  logic            ex_load_pending;
  logic            hazard;
  logic            kill;

  assign rs[1]      = os.i_os_rs1;
  assign rs[2]      = os.i_os_rs2;
  assign rs_used[1] = os.i_os_rs1_used;
  assign rs_used[2] = os.i_os_rs2_used;

  assign os.o_os_raddr[1] = os.i_os_rs1;
  assign os.o_os_raddr[2] = os.i_os_rs2;

  // An instruction in EX can forward its ALU result only when it is not a
  // load; a load's data does not exist until MEM.
  assign ex_fwd_ok = os.o_os_ex_valid & os.o_os_ex_wen & ~os.o_os_ex_is_load;

  // Operand selection, first match wins. The WB bypass is required because
  // the register file writes on the same edge and still returns the old
  // value this cycle. rs == 0 is checked first, so a producer that claims
  // to write x0 is never forwarded.
  always_comb begin
    for (int n = 1; n <= 2; n++) begin
      operand[n] = '0;
      if (rs[n] == 5'd0) begin
        operand[n] = '0;
      end else if (ex_fwd_ok && (os.o_os_ex_rd == rs[n])) begin
        operand[n] = os.i_os_ex_result;
      end else if (os.i_os_mem_wen && (os.i_os_mem_rd == rs[n])) begin
        operand[n] = os.i_os_mem_data;
      end else if (os.i_os_wb_wen && (os.i_os_wb_rd == rs[n])) begin
        operand[n] = os.i_os_wb_data;
      end else begin
        operand[n] = os.i_os_rf_rdata[n];
      end
    end
  end

  // Load-use: a load to a non-zero register sits in EX and the ID
  // instruction actually reads that register. Unused rs fields are ignored
  // because decoders leave garbage in them.
  assign ex_load_pending = os.o_os_ex_valid & os.o_os_ex_is_load &
                           os.o_os_ex_wen & (os.o_os_ex_rd != 5'd0);

  always_comb begin
    hazard = 1'b0;
    if (os.i_os_valid && ex_load_pending) begin
      for (int n = 1; n <= 2; n++) begin
        if (rs_used[n] && (rs[n] == os.o_os_ex_rd)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // A redirect discards the ID instruction anyway, so no stall is needed.
  assign os.o_os_stall = hazard & ~os.i_os_flush;

  // Flush and hazard both leave a bubble in EX. Only the control bits are
  // cleared; the data fields keep their last value.
  assign kill = os.i_os_flush | hazard;

  // ID/EX pipeline register.
  always_ff @(posedge i_os_clk or posedge i_os_rst) begin
    if (i_os_rst) begin
      os.o_os_ex_valid    <= 1'b0;
      os.o_os_ex_wen      <= 1'b0;
      os.o_os_ex_is_load  <= 1'b0;
      os.o_os_ex_rd       <= 5'd0;
      os.o_os_ex_rs1_data <= '0;
      os.o_os_ex_rs2_data <= '0;
      os.o_os_ex_pc       <= '0;
      os.o_os_ex_imm      <= '0;
    end else if (kill) begin
      os.o_os_ex_valid    <= 1'b0;
      os.o_os_ex_wen      <= 1'b0;
      os.o_os_ex_is_load  <= 1'b0;
    end else begin
      os.o_os_ex_valid    <= os.i_os_valid;
      os.o_os_ex_wen      <= os.i_os_wen & os.i_os_valid;
      os.o_os_ex_is_load  <= os.i_os_is_load & os.i_os_valid;
      os.o_os_ex_rd       <= os.i_os_rd;
      os.o_os_ex_rs1_data <= operand[1];
      os.o_os_ex_rs2_data <= operand[2];
      os.o_os_ex_pc       <= os.i_os_pc;
      os.o_os_ex_imm      <= os.i_os_imm;
    end
  end

  // Saturating stall-cycle counter; it stops at all-ones, never wraps.
  always_ff @(posedge i_os_clk or posedge i_os_rst) begin
    if (i_os_rst) begin
      os.o_os_stall_cnt <= '0;
    end else if (os.o_os_stall && (os.o_os_stall_cnt != {CNT_W{1'b1}})) begin
      os.o_os_stall_cnt <= os.o_os_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_rv_operand_stage
//
// Self-checking bench for rv_operand_stage. Every driven ID instruction
// pushes its expected ID/EX contents onto a scoreboard queue. The entry is
// popped and compared after the capturing edge. A second instance with
// CNT_W = 2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_rv_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rv_operand_stage_if #(.XLEN(32), .CNT_W(16)) os ();
  rv_operand_stage_if #(.XLEN(32), .CNT_W(2))  os2 ();

  rv_operand_stage #(.XLEN(32), .CNT_W(16)) dut (
    .i_os_clk (clk),
    .i_os_rst (rst),
    .os       (os)
  );

  rv_operand_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .i_os_clk (clk),
    .i_os_rst (rst),
    .os       (os2)
  );

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        is_load;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
  } ex_t;

  ex_t         sb_q [$];
  ex_t         last;
  ex_t         got;
  ex_t         exp_e;
  logic [15:0] exp_cnt;
  logic [1:0]  exp_cnt2;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic ex_t observe();
    ex_t r;
    r.valid   = os.o_os_ex_valid;
    r.wen     = os.o_os_ex_wen;
    r.is_load = os.o_os_ex_is_load;
    r.rd      = os.o_os_ex_rd;
    r.rs1     = os.o_os_ex_rs1_data;
    r.rs2     = os.o_os_ex_rs2_data;
    r.pc      = os.o_os_ex_pc;
    r.imm     = os.o_os_ex_imm;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    os.i_os_valid = 1'b0;      os.i_os_rs1 = 5'd0;        os.i_os_rs2 = 5'd0;
    os.i_os_rs1_used = 1'b0;   os.i_os_rs2_used = 1'b0;   os.i_os_rd = 5'd0;
    os.i_os_wen = 1'b0;        os.i_os_is_load = 1'b0;
    os.i_os_pc = 32'd0;        os.i_os_imm = 32'd0;
    os.i_os_rf_rdata[1] = 32'd0;  os.i_os_rf_rdata[2] = 32'd0;
    os.i_os_ex_result = 32'd0;
    os.i_os_mem_rd = 5'd0;     os.i_os_mem_wen = 1'b0;    os.i_os_mem_data = 32'd0;
    os.i_os_wb_rd = 5'd0;      os.i_os_wb_wen = 1'b0;     os.i_os_wb_data = 32'd0;
    os.i_os_flush = 1'b0;
  endtask

  task automatic clear_inputs2();
    os2.i_os_valid = 1'b0;     os2.i_os_rs1 = 5'd0;       os2.i_os_rs2 = 5'd0;
    os2.i_os_rs1_used = 1'b0;  os2.i_os_rs2_used = 1'b0;  os2.i_os_rd = 5'd0;
    os2.i_os_wen = 1'b0;       os2.i_os_is_load = 1'b0;
    os2.i_os_pc = 32'd0;       os2.i_os_imm = 32'd0;
    os2.i_os_rf_rdata[1] = 32'd0; os2.i_os_rf_rdata[2] = 32'd0;
    os2.i_os_ex_result = 32'd0;
    os2.i_os_mem_rd = 5'd0;    os2.i_os_mem_wen = 1'b0;   os2.i_os_mem_data = 32'd0;
    os2.i_os_wb_rd = 5'd0;     os2.i_os_wb_wen = 1'b0;    os2.i_os_wb_data = 32'd0;
    os2.i_os_flush = 1'b0;
  endtask

  // Idle cycle: valid = 0 still captures data fields, all of which are zero.
  task automatic idle();
    clear_inputs();
    tick();
    last = '0;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                          input logic w, input logic ld, input logic [31:0] pc,
                          input logic [31:0] imm);
    os.i_os_valid = v;   os.i_os_rs1 = r1; os.i_os_rs1_used = u1;
    os.i_os_rs2 = r2;    os.i_os_rs2_used = u2;
    os.i_os_rd = rd;     os.i_os_wen = w;  os.i_os_is_load = ld;
    os.i_os_pc = pc;     os.i_os_imm = imm;
  endtask

  // Expected capture of the currently driven ID instruction.
  task automatic push_capture(input logic [31:0] a, input logic [31:0] b);
    ex_t e;
    e.valid   = os.i_os_valid;
    e.wen     = os.i_os_wen & os.i_os_valid;
    e.is_load = os.i_os_is_load & os.i_os_valid;
    e.rd      = os.i_os_rd;
    e.rs1     = a;
    e.rs2     = b;
    e.pc      = os.i_os_pc;
    e.imm     = os.i_os_imm;
    last      = e;
    sb_q.push_back(e);
  endtask

  // Expected bubble: control bits clear, data fields hold.
  task automatic push_bubble();
    ex_t e;
    e         = last;
    e.valid   = 1'b0;
    e.wen     = 1'b0;
    e.is_load = 1'b0;
    last      = e;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    clear_inputs2();
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("[TB] FAIL reset_regs got=%h exp=0", got);
    end
    n_cmp++;
    if (os.o_os_stall_cnt !== 16'd0) begin
      n_bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", os.o_os_stall_cnt);
    end
    #2 rst = 1'b0;
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 32'h100, 32'h7);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL capture_after_reset got=%h exp=%h", got, exp_e);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (os.o_os_ex_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL async_reset_valid got=%b exp=0", os.o_os_ex_valid);
    end
    got = observe(); n_cmp++;
    if (got !== '0) begin
      n_bad++; $display("[TB] FAIL async_reset_regs got=%h exp=0", got);
    end
    #1 rst = 1'b0;
    last = '0;
    exp_cnt = 16'd0;
    exp_cnt2 = 2'd0;
    clear_inputs();
  endtask

  task automatic test_wb_bypass();
    idle();
    drive_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 32'h300, 32'h1);
    os.i_os_rf_rdata[1] = 32'd0;
    os.i_os_wb_rd = 5'd5; os.i_os_wb_wen = 1'b1; os.i_os_wb_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (os.o_os_raddr[1] !== 5'd5) begin
      n_bad++; $display("[TB] FAIL raddr1 got=%0d exp=5", os.o_os_raddr[1]);
    end
    push_capture(32'hDEADBEEF, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL wb_bypass got=%h exp=%h", got, exp_e);
    end
    // Same read with WB not writing: register file value is used.
    os.i_os_wb_wen = 1'b0;
    os.i_os_rf_rdata[1] = 32'h1234;
    os.i_os_pc = 32'h304;
    push_capture(32'h1234, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL rf_read got=%h exp=%h", got, exp_e);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 32'h400, 32'h0);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 32'h404, 32'h0);
    os.i_os_ex_result = 32'hA1;
    os.i_os_rf_rdata[1] = 32'hBAD;
    push_capture(32'hA1, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL b2b_ex_fwd got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 32'h408, 32'h0);
    os.i_os_ex_result = 32'hB2;
    os.i_os_mem_rd = 5'd10; os.i_os_mem_wen = 1'b1; os.i_os_mem_data = 32'hA1;
    os.i_os_rf_rdata[2] = 32'hBAD;
    push_capture(32'hA1, 32'hB2);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL b2b_mem_ex_fwd got=%h exp=%h", got, exp_e);
    end
  endtask

  task automatic test_priority();
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h40, 32'h4);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL prio_producer got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 32'h44, 32'h8);
    os.i_os_ex_result = 32'h11;
    os.i_os_mem_rd = 5'd5; os.i_os_mem_wen = 1'b1; os.i_os_mem_data = 32'h22;
    os.i_os_wb_rd = 5'd5;  os.i_os_wb_wen = 1'b1;  os.i_os_wb_data = 32'h33;
    os.i_os_rf_rdata[2] = 32'h44;
    push_capture(32'd0, 32'h11);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL prio_ex_wins got=%h exp=%h", got, exp_e);
    end
    // Now a load to x5 occupies EX: the reader must stall, not take 0x11.
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 32'h48, 32'h0);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL prio_load_issue got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 32'h4C, 32'h0);
    #1;
    n_cmp++;
    if (os.o_os_stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL prio_load_stall got=%b exp=1", os.o_os_stall);
    end
    push_bubble();
    exp_cnt = exp_cnt + 16'd1;
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL prio_bubble got=%h exp=%h", got, exp_e);
    end
    n_cmp++;
    if (os.o_os_stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL prio_stall_clear got=%b exp=0", os.o_os_stall);
    end
    push_capture(32'd0, 32'h22);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL prio_mem_after_bubble got=%h exp=%h", got, exp_e);
    end
  endtask

  task automatic test_load_use();
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h500, 32'h0);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL lu_load got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 32'h504, 32'h0);
    os.i_os_rf_rdata[1] = 32'h1234;
    os.i_os_rf_rdata[2] = 32'h1111;
    #1;
    n_cmp++;
    if (os.o_os_stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL lu_stall got=%b exp=1", os.o_os_stall);
    end
    push_bubble();
    exp_cnt = exp_cnt + 16'd1;
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL lu_bubble got=%h exp=%h", got, exp_e);
    end
    n_cmp++;
    if (os.o_os_stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL lu_one_cycle got=%b exp=0", os.o_os_stall);
    end
    os.i_os_mem_rd = 5'd7; os.i_os_mem_wen = 1'b1; os.i_os_mem_data = 32'hCAFE0000;
    push_capture(32'hCAFE0000, 32'h1111);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL lu_mem_fwd got=%h exp=%h", got, exp_e);
    end
    n_cmp++;
    if (os.o_os_stall_cnt !== exp_cnt) begin
      n_bad++; $display("[TB] FAIL lu_cnt got=%0d exp=%0d", os.o_os_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_x0();
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h600, 32'h0);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL x0_producer got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 32'h604, 32'h0);
    os.i_os_ex_result = 32'h55;
    os.i_os_mem_rd = 5'd0; os.i_os_mem_wen = 1'b1; os.i_os_mem_data = 32'h66;
    os.i_os_wb_rd = 5'd0;  os.i_os_wb_wen = 1'b1;  os.i_os_wb_data = 32'h77;
    os.i_os_rf_rdata[1] = 32'h99;
    os.i_os_rf_rdata[2] = 32'h1;
    push_capture(32'd0, 32'h1);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL x0_no_fwd got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h608, 32'h0);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL x0_load got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 32'h60C, 32'h0);
    #1;
    n_cmp++;
    if (os.o_os_stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL x0_no_stall got=%b exp=0", os.o_os_stall);
    end
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL x0_use got=%h exp=%h", got, exp_e);
    end
  endtask

  task automatic test_flush();
    idle();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 32'h200, 32'h10);
    push_capture(32'd0, 32'd0);
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL flush_load got=%h exp=%h", got, exp_e);
    end
    drive_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'h204, 32'h0);
    os.i_os_flush = 1'b1;
    #1;
    n_cmp++;
    if (os.o_os_stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL flush_no_stall got=%b exp=0", os.o_os_stall);
    end
    push_bubble();
    tick();
    got = observe(); exp_e = sb_q.pop_front(); n_cmp++;
    if (got !== exp_e) begin
      n_bad++; $display("[TB] FAIL flush_bubble got=%h exp=%h", got, exp_e);
    end
    n_cmp++;
    if (os.o_os_stall_cnt !== exp_cnt) begin
      n_bad++; $display("[TB] FAIL flush_cnt got=%0d exp=%0d", os.o_os_stall_cnt, exp_cnt);
    end
    os.i_os_flush = 1'b0;
  endtask

  task automatic test_saturate();
    idle();
    for (int i = 0; i < 5; i++) begin
      os2.i_os_valid = 1'b1; os2.i_os_rd = 5'd7; os2.i_os_wen = 1'b1;
      os2.i_os_is_load = 1'b1; os2.i_os_rs1 = 5'd0; os2.i_os_rs1_used = 1'b0;
      tick();
      os2.i_os_is_load = 1'b0; os2.i_os_rd = 5'd8;
      os2.i_os_rs1 = 5'd7; os2.i_os_rs1_used = 1'b1;
      #1;
      n_cmp++;
      if (os2.o_os_stall !== 1'b1) begin
        n_bad++; $display("[TB] FAIL sat_stall_%0d got=%b exp=1", i, os2.o_os_stall);
      end
      tick();
      if (exp_cnt2 != 2'd3) exp_cnt2 = exp_cnt2 + 2'd1;
      n_cmp++;
      if (os2.o_os_stall_cnt !== exp_cnt2) begin
        n_bad++; $display("[TB] FAIL sat_cnt_%0d got=%0d exp=%0d", i, os2.o_os_stall_cnt, exp_cnt2);
      end
    end
    clear_inputs2();
    tick();
  endtask

  initial begin
    last     = '0;
    exp_cnt  = 16'd0;
    exp_cnt2 = 2'd0;
    test_reset();
    test_wb_bypass();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_x0();
    test_flush();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_operand_stage.md
Name: rv_operand_stage

Overview:
ID-to-EX operand stage of the rv32i pipeline. It drives the register-file read addresses and resolves RAW hazards by bypassing from EX, MEM and WB. It detects load-use hazards and stalls upstream for them. It registers the resolved operands plus control into the ID/EX pipeline register consumed by the ALU.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of saturating stall-cycle counter

Ports:
i_os_clk  input  1  clock
i_os_rst  input  1  reset, asynchronous, active-high
i_os_valid  input  1  ID holds a valid instruction
i_os_rs1, i_os_rs2  input  5 each  source register indices
i_os_rs1_used, i_os_rs2_used  input  1 each  instruction reads rs1 / rs2
i_os_rd  input  5  destination index
i_os_wen  input  1  instruction writes rd
i_os_is_load  input  1  instruction is a load
i_os_pc, i_os_imm  input  XLEN each  PC and decoded immediate
o_os_raddr  output  5 x [1:2]  register-file read addresses; combinational, equal to {rs1, rs2}
i_os_rf_rdata  input  XLEN x [1:2]  register-file read data; combinational
i_os_ex_result  input  XLEN  ALU result of the instruction currently in EX
i_os_mem_rd, i_os_mem_wen, i_os_mem_data  input  5/1/XLEN  MEM-stage writeback candidate
i_os_wb_rd, i_os_wb_wen, i_os_wb_data  input  5/1/XLEN  WB-stage write, same values as the register-file write port
i_os_flush  input  1  kill the ID instruction and the ID/EX slot (branch/trap redirect)
o_os_stall  output  1  combinational; hold PC and IF/ID this cycle
o_os_ex_valid, o_os_ex_wen, o_os_ex_is_load  output  1 each  registered
o_os_ex_rd  output  5  registered
o_os_ex_rs1_data, o_os_ex_rs2_data, o_os_ex_pc, o_os_ex_imm  output  XLEN each  registered
o_os_stall_cnt  output  CNT_W  registered, saturating count of stall cycles

Behaviour:
- Reset (asynchronous, immediate): every registered output is 0, including o_os_ex_valid and o_os_stall_cnt.
- Operand selection, per source n in {1,2}, first match wins:
  - rs == 0 -> 0.
  - o_os_ex_valid & o_os_ex_wen & ~o_os_ex_is_load & o_os_ex_rd == rs -> i_os_ex_result.
  - i_os_mem_wen & i_os_mem_rd == rs -> i_os_mem_data.
  - i_os_wb_wen & i_os_wb_rd == rs -> i_os_wb_data. This bypass is mandatory because the register file updates on the same edge and returns the old value.
  - Otherwise -> i_os_rf_rdata[n].
- Hazard is 1 when all of the following hold:
  - i_os_valid
  - o_os_ex_valid & o_os_ex_is_load & o_os_ex_wen & o_os_ex_rd != 0
  - (i_os_rs1_used & rs1 == o_os_ex_rd) | (i_os_rs2_used & rs2 == o_os_ex_rd)
- o_os_stall = hazard & ~i_os_flush.
- ID/EX register update at each posedge, priority order:
  1. i_os_flush: ex_valid <= 0, ex_wen <= 0, ex_is_load <= 0. Data fields hold.
  2. hazard: insert a bubble with the same effect as flush. The ID instruction is held upstream and re-evaluated next cycle, when the load sits in MEM and is bypassed.
  3. Otherwise: capture the selected operands plus i_os_rd, pc, imm. ex_valid <= i_os_valid, ex_wen <= i_os_wen & i_os_valid, ex_is_load <= i_os_is_load & i_os_valid.
- Latency: 1 cycle from ID to EX outputs. A load-use pair costs exactly 1 bubble.
- o_os_stall_cnt increments on every cycle with o_os_stall = 1 and saturates at all-ones.
- Only x0 is special. Forwarding of rd = 0 never occurs, even if a producer claims wen.

Test Plan:
- Async reset mid-stream: assert i_os_rst between edges -> all registered outputs 0 immediately; o_os_ex_valid = 0 with no clock edge.
- WB bypass: WB writes x5 = 0xDEADBEEF while ID reads rs1 = 5 and i_os_rf_rdata[1] = 0 -> next edge o_os_ex_rs1_data = 0xDEADBEEF.
- Priority: EX rd 5 result 0x11, MEM rd 5 0x22, WB rd 5 0x33, ID rs2 = 5 -> o_os_ex_rs2_data = 0x11. Then EX marked load -> stall instead of a 0x11 forward.
- Load-use: lw x7, then add x8, x7, x1 -> o_os_stall = 1 for one cycle, one bubble (ex_valid = 0). Next cycle MEM data 0xCAFE0000 is forwarded to rs1, and stall_cnt = 1.
- x0 rule: EX wen with rd = 0 result 0x55, ID rs1 = 0 -> operand 0. Load to x0 followed by use of x0 -> no stall.
- Flush vs stall: hazard and i_os_flush in the same cycle -> o_os_stall = 0, bubble inserted, stall_cnt unchanged. Also run CNT_W = 2 with 5 stalls -> count saturates at 3.
